alu_issue_ctrl: RTL and testbench

Issue controller that drives the 32-bit combinational ALU. It accepts operation requests on a valid/ready handshake and decodes a compact 4-bit op code into the ALU's 6-bit `alufn`. It registers the operands onto the ALU ports, captures `otp`/`zero`/`overflow`, and presents the result on a second valid/ready handshake. It sits between the instruction decode stage and register-file writeback.

---
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue controller in front of a 32-bit combinational ALU.
// It accepts one request, decodes the 4-bit op into a 6-bit alufn, drives
// registered operands onto the ALU for one cycle, captures the ALU result,
// and then holds that result until it is consumed.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state, never on in_valid. Once
// out_valid is high, it and all out_* fields stay stable until out_ready.
//
// Optional feature: define ALU_ISSUE_TRAP_EN to trap illegal ops (9..15).
// A trapped op skips the ALU and completes with out_err=1 one cycle after it
// is accepted. Without the macro, illegal ops run as ADD and out_err is 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   in_op, in_a, in_b, in_tag  request payload
//   alu_a, alu_b, alu_alufn    registered ALU operand and function ports
//   alu_otp/zero/overflow      ALU result inputs
//   out_valid/out_ready        result handshake
//   out_data/zero/ovf/err/tag  captured result
//   op_count                   completed results, saturates at 0xFFFF
//   dbg_state                  current FSM state (0 IDLE, 1 ISSUE, 2 HOLD)
module alu_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_alufn,
  input  logic [31:0]      alu_otp,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      op_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [5:0]       dec_fn;
  logic             accept;
  logic             trap_take;
  logic [TAG_W-1:0] tag_q;

  // Op decode. Illegal codes map to ADD; the trap build overrides that path.
  always_comb begin
    dec_fn = 6'b000000;
    case (in_op)
      4'd0:    dec_fn = 6'b000000;
      4'd1:    dec_fn = 6'b000001;
      4'd2:    dec_fn = 6'b000010;
      4'd3:    dec_fn = 6'b000100;
      4'd4:    dec_fn = 6'b000101;
      4'd5:    dec_fn = 6'b000110;
      4'd6:    dec_fn = 6'b001000;
      4'd7:    dec_fn = 6'b001001;
      4'd8:    dec_fn = 6'b001011;
      default: dec_fn = 6'b000000;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign dbg_state = state;
  assign accept    = in_valid & in_ready;

`ifdef ALU_ISSUE_TRAP_EN
  logic err_q;
  assign trap_take = accept & (in_op > 4'd8);
  assign out_err   = err_q;
`else
  assign trap_take = 1'b0;
  assign out_err   = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = trap_take ? HOLD : ISSUE;
      ISSUE:   state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ALU port registers: loaded only for ops that actually use the ALU, so
  // they keep their last values through HOLD, IDLE and trapped ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_alufn <= '0;
      tag_q     <= '0;
    end else if (accept && !trap_take) begin
      alu_a     <= in_a;
      alu_b     <= in_b;
      alu_alufn <= dec_fn;
      tag_q     <= in_tag;
    end
  end

  // Result registers: written when leaving ISSUE, or on a trapped accept.
  // They are never written in HOLD, which keeps a stalled result stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
      out_tag  <= '0;
`ifdef ALU_ISSUE_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else if (state == ISSUE) begin
      out_data <= alu_otp;
      out_zero <= alu_zero;
      out_ovf  <= alu_overflow;
      out_tag  <= tag_q;
`ifdef ALU_ISSUE_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else if (trap_take) begin
      out_data <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
      out_tag  <= in_tag;
`ifdef ALU_ISSUE_TRAP_EN
      err_q    <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if ((state == HOLD) && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. A behavioural ALU drives the alu_* inputs.
// A transaction-level model predicts accepts, result timing, result fields,
// the ALU port values and op_count. Every negedge it is compared against the
// DUT. Directed tests also check hand-computed literal values.
module tb_alu_issue_ctrl;
  localparam int TW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [TW-1:0] in_tag;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [5:0]    alu_alufn;
  logic [31:0]   alu_otp;
  logic          alu_zero;
  logic          alu_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_zero;
  logic          out_ovf;
  logic          out_err;
  logic [TW-1:0] out_tag;
  logic [15:0]   op_count;
  logic [1:0]    dbg_state;

  alu_issue_ctrl #(.TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_alufn(alu_alufn),
    .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err),
    .out_tag(out_tag), .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_ISSUE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU behaviour
  function automatic logic [31:0] alu_res(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b000010: return a * b;
      6'b000100: return a & b;
      6'b000101: return a | b;
      6'b000110: return a ^ b;
      6'b001000: return a << b[4:0];
      6'b001001: return a >> b[4:0];
      6'b001011: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = alu_res(fn, a, b);
    if (fn == 6'b000000) return (a[31] == b[31]) && (r[31] != a[31]);
    if (fn == 6'b000001) return (a[31] != b[31]) && (r[31] != a[31]);
    return 1'b0;
  endfunction

  function automatic logic [5:0] op_to_fn(input logic [3:0] op);
    case (op)
      4'd0: return 6'b000000;
      4'd1: return 6'b000001;
      4'd2: return 6'b000010;
      4'd3: return 6'b000100;
      4'd4: return 6'b000101;
      4'd5: return 6'b000110;
      4'd6: return 6'b001000;
      4'd7: return 6'b001001;
      4'd8: return 6'b001011;
      default: return 6'b000000;
    endcase
  endfunction

  always_comb begin
    alu_otp      = alu_res(alu_alufn, alu_a, alu_b);
    alu_zero     = (alu_otp == 32'd0);
    alu_overflow = alu_ovf(alu_alufn, alu_a, alu_b);
  end

  // Model: one expected transaction per accepted request
  typedef struct {
    logic [31:0]   data;
    logic          zero;
    logic          ovf;
    logic          err;
    logic [TW-1:0] tag;
    int            rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [5:0]  m_fn;
  int          m_done;
  int          cyc_m;

  task automatic model_clear();
    exp_q.delete();
    m_a    = '0;
    m_b    = '0;
    m_fn   = '0;
    m_done = 0;
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (rst_n) begin
      logic ev;
      exp_t e;
      cyc_m++;
      chk(in_ready == (exp_q.size() == 0), "in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      ev = (exp_q.size() != 0) && (cyc_m >= exp_q[0].rdy);
      chk(out_valid == ev, "out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk(out_data == exp_q[0].data, "out_data", out_data, exp_q[0].data);
        chk(out_zero == exp_q[0].zero, "out_zero", 32'(out_zero), 32'(exp_q[0].zero));
        chk(out_ovf == exp_q[0].ovf, "out_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
        chk(out_err == exp_q[0].err, "out_err", 32'(out_err), 32'(exp_q[0].err));
        chk(out_tag == exp_q[0].tag, "out_tag", 32'(out_tag), 32'(exp_q[0].tag));
      end
      chk(alu_a == m_a, "alu_a", alu_a, m_a);
      chk(alu_b == m_b, "alu_b", alu_b, m_b);
      chk(alu_alufn == m_fn, "alu_alufn", 32'(alu_alufn), 32'(m_fn));
      chk(32'(op_count) == m_done, "op_count", 32'(op_count), m_done);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (m_done < 65535) m_done++;
      end
      if (in_valid && in_ready) begin
        if (TRAP && in_op > 4'd8) begin
          e.data = 0; e.zero = 0; e.ovf = 0; e.err = 1; e.tag = in_tag;
          e.rdy = cyc_m + 1;
        end else begin
          e.data = alu_res(op_to_fn(in_op), in_a, in_b);
          e.zero = (e.data == 32'd0);
          e.ovf  = alu_ovf(op_to_fn(in_op), in_a, in_b);
          e.err  = 0;
          e.tag  = in_tag;
          e.rdy  = cyc_m + 2;
          m_a  = in_a;
          m_b  = in_b;
          m_fn = op_to_fn(in_op);
        end
        exp_q.push_back(e);
      end
    end
  end

  // driver tasks
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag, input int stall,
                       output int lat, output logic [31:0] d, output logic z,
                       output logic er, output logic [TW-1:0] t, output logic [5:0] fn1);
    int  n;
    bit  acc;
    bit  got;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b0;
    n = 0; acc = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      n++;
    end
    chk(acc, "accept_timeout", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; got = 0; fn1 = '0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) fn1 = alu_alufn;
      if (out_valid) got = 1;
    end
    chk(got, "result_timeout", 32'(got), 32'd1);
    d = out_data; z = out_zero; er = out_err; t = out_tag;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      chk(out_valid == 1'b1, "stall_valid", 32'(out_valid), 32'd1);
      chk(out_data == d, "stall_data", out_data, d);
      chk(in_ready == 1'b0, "stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int            lat;
    logic [31:0]   d;
    logic          z;
    logic          er;
    logic [TW-1:0] t;
    logic [5:0]    fn1;
    int            c0;
    int            k;
    int            acc_t[$];
    int            cyc;

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; cyc_m = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(op_count == 16'd0, "rst_op_count", 32'(op_count), 32'd0);
    chk(alu_alufn == 6'd0, "rst_alufn", 32'(alu_alufn), 32'd0);
    chk(out_data == 32'd0, "rst_out_data", out_data, 32'd0);

    // ADD 5+7
    do_op(4'd0, 32'd5, 32'd7, 5'd3, 0, lat, d, z, er, t, fn1);
    chk(lat == 2, "add_latency", 32'(lat), 32'd2);
    chk(fn1 == 6'b000000, "add_alufn", 32'(fn1), 32'd0);
    chk(d == 32'd12, "add_data", d, 32'd12);
    chk(z == 1'b0, "add_zero", 32'(z), 32'd0);
    chk(t == 5'd3, "add_tag", 32'(t), 32'd3);
    chk(op_count == 16'd1, "add_count", 32'(op_count), 32'd1);

    // SUB 9-9 with a 5-cycle stall
    do_op(4'd1, 32'd9, 32'd9, 5'd17, 5, lat, d, z, er, t, fn1);
    chk(fn1 == 6'b000001, "sub_alufn", 32'(fn1), 32'd1);
    chk(d == 32'd0, "sub_data", d, 32'd0);
    chk(z == 1'b1, "sub_zero", 32'(z), 32'd1);
    chk(op_count == 16'd2, "sub_count", 32'(op_count), 32'd2);

    // illegal op 12, a=1 b=2
    do_op(4'd12, 32'd1, 32'd2, 5'd9, 0, lat, d, z, er, t, fn1);
    if (TRAP) begin
      chk(lat == 1, "trap_latency", 32'(lat), 32'd1);
      chk(er == 1'b1, "trap_err", 32'(er), 32'd1);
      chk(d == 32'd0, "trap_data", d, 32'd0);
    end else begin
      chk(lat == 2, "ill_latency", 32'(lat), 32'd2);
      chk(er == 1'b0, "ill_err", 32'(er), 32'd0);
      chk(d == 32'd3, "ill_data", d, 32'd3);
    end
    chk(op_count == 16'd3, "ill_count", 32'(op_count), 32'd3);

    // back-to-back stream of ops 0..8
    c0 = int'(op_count);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_op = 4'd0;
    in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
    k = 0; cyc = 0;
    while (k < 9 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) begin
        acc_t.push_back(cyc);
        k++;
      end
      @(posedge clk); #1;
      if (k < 9) begin
        in_op = 4'(k); in_a = $urandom; in_b = $urandom_range(0, 40); in_tag = 5'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk(k == 9, "stream_accepts", 32'(k), 32'd9);
    for (int i = 1; i < acc_t.size(); i++)
      chk(acc_t[i] - acc_t[i-1] == 3, "stream_interval", 32'(acc_t[i] - acc_t[i-1]), 32'd3);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    chk(int'(op_count) == c0 + 9, "stream_count", 32'(op_count), 32'(c0 + 9));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
      in_tag    = 5'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b0;

    // reset pulse while holding a result
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd1;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      k++;
    end
    chk(out_valid == 1'b1, "pre_reset_hold", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
    chk(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);
    chk(op_count == 16'd0, "reset_op_count", 32'(op_count), 32'd0);
    chk(out_data == 32'd0, "reset_out_data", out_data, 32'd0);
    chk(alu_a == 32'd0, "reset_alu_a", alu_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    chk(dbg_state == 2'd0, "reset_ignores_in", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(4'd5, 32'hF0F0_0000, 32'h0FF0_0001, 5'd22, 1, lat, d, z, er, t, fn1);
    chk(d == 32'hFF00_0001, "post_reset_data", d, 32'hFF00_0001);
    chk(t == 5'd22, "post_reset_tag", 32'(t), 32'd22);
    chk(op_count == 16'd1, "post_reset_count", 32'(op_count), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
